divisor_segmentado_param: RTL

// Parametrised, fully pipelined integer divider (successor of the fixed 32-stage divider).

---
 rtl/divisor_segmentado_param.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/divisor_segmentado_param.sv
// divisor_segmentado_param: fully pipelined integer divider, one operation per clock.
//
// Restoring division on operand magnitudes, BITS_PER_STAGE quotient bits per stage, with
// per-operation signed/unsigned mode, a pass-through tag and a synchronous flush.
// Pipeline: input capture -> stage 0 (magnitudes, signs, special cases) -> N iteration
// stages -> output stage (sign correction, special cases). Latency N+2 clocks.
//
// Ports
//   CLK      clock, rising edge
//   RSTn     asynchronous reset, active low
//   START    launch a division this cycle (SIGNED, NUM, DEN, TAG_IN sampled)
//   SIGNED   1: two's-complement operands, 0: unsigned
//   NUM/DEN  dividend / divisor
//   TAG_IN   user tag returned with the result
//   FLUSH    kill every operation accepted before this edge
//   COC/RES  quotient / remainder
//   DIV0     result came from DEN == 0
//   TAG_OUT  tag of the completing operation
//   DONE     one-cycle pulse, outputs valid; outputs hold while DONE is low
module divisor_segmentado_param #(
  parameter int unsigned tamanyo        = 32,
  parameter int unsigned BITS_PER_STAGE = 1,
  parameter int unsigned TAGW           = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               START,
  input  logic               SIGNED,
  input  logic [tamanyo-1:0] NUM,
  input  logic [tamanyo-1:0] DEN,
  input  logic [TAGW-1:0]    TAG_IN,
  input  logic               FLUSH,
  output logic [tamanyo-1:0] COC,
  output logic [tamanyo-1:0] RES,
  output logic               DIV0,
  output logic [TAGW-1:0]    TAG_OUT,
  output logic               DONE
);

  localparam int unsigned W  = tamanyo;
  localparam int unsigned N  = tamanyo / BITS_PER_STAGE;
  localparam int unsigned RW = tamanyo + BITS_PER_STAGE;

  localparam logic [W-1:0] MostNeg = {1'b1, {(W-1){1'b0}}};

  if ((tamanyo < 4) || (tamanyo % BITS_PER_STAGE != 0) ||
      !((BITS_PER_STAGE == 1) || (BITS_PER_STAGE == 2) || (BITS_PER_STAGE == 4)))
  begin : g_param_check
    $error("divisor_segmentado_param: invalid tamanyo/BITS_PER_STAGE combination");
  end

  // ---------------------------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------------------------
  logic            in_vld_q;
  logic            in_sgn_q;
  logic [W-1:0]    in_num_q;
  logic [W-1:0]    in_den_q;
  logic [TAGW-1:0] in_tag_q;

  // Operand registers only load on START; their contents are irrelevant while invalid.
  always_ff @(posedge CLK) begin
    if (START) begin
      in_sgn_q <= SIGNED;
      in_num_q <= NUM;
      in_den_q <= DEN;
      in_tag_q <= TAG_IN;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stage 0: magnitudes, result signs and special cases
  // ---------------------------------------------------------------------------------------
  logic         s0_num_neg;
  logic         s0_den_neg;
  logic [W-1:0] s0_a;
  logic [W-1:0] s0_b;
  logic         s0_div0;
  logic         s0_ovf;

  always_comb begin
    s0_num_neg = in_sgn_q & in_num_q[W-1];
    s0_den_neg = in_sgn_q & in_den_q[W-1];
    // Negating the most negative value yields 2^(W-1), which is its correct unsigned magnitude.
    s0_a       = s0_num_neg ? -in_num_q : in_num_q;
    s0_b       = s0_den_neg ? -in_den_q : in_den_q;
    s0_div0    = (in_den_q == '0);
    s0_ovf     = in_sgn_q & (in_num_q == MostNeg) & (in_den_q == '1);
  end

  // ---------------------------------------------------------------------------------------
  // Iteration pipeline. Index 0 is the stage-0 register, index i holds the state after i
  // iteration stages. aq_q starts as the dividend magnitude and fills with quotient bits from
  // the bottom as dividend bits are shifted out of the top into the partial remainder.
  // ---------------------------------------------------------------------------------------
  logic [N:0]      vld_q;
  logic [W-1:0]    rem_q  [0:N];
  logic [W-1:0]    aq_q   [0:N];
  logic [W-1:0]    b_q    [0:N-1];
  logic [W-1:0]    num_q  [0:N];
  logic [TAGW-1:0] tag_q  [0:N];
  logic [N:0]      negq_q;
  logic [N:0]      negr_q;
  logic [N:0]      dz_q;
  logic [N:0]      ov_q;

  logic [W-1:0]    rem_d  [1:N];
  logic [W-1:0]    aq_d   [1:N];

  always_comb begin
    rem_d = '{default: '0};
    aq_d  = '{default: '0};
    for (int i = 1; i <= int'(N); i++) begin
      logic [RW-1:0] r;
      logic [RW-1:0] bx;
      logic [W-1:0]  aq;
      r  = {{BITS_PER_STAGE{1'b0}}, rem_q[i-1]};
      bx = {{BITS_PER_STAGE{1'b0}}, b_q[i-1]};
      aq = aq_q[i-1];
      for (int j = 0; j < int'(BITS_PER_STAGE); j++) begin
        r  = {r[RW-2:0], aq[W-1]};
        aq = {aq[W-2:0], 1'b0};
        if (r >= bx) begin
          r     = r - bx;
          aq[0] = 1'b1;
        end
      end
      // The partial remainder is back below the divisor, so it fits in W bits.
      rem_d[i] = r[W-1:0];
      aq_d[i]  = aq;
    end
  end

  always_ff @(posedge CLK) begin
    rem_q[0]  <= '0;
    aq_q[0]   <= s0_a;
    b_q[0]    <= s0_b;
    num_q[0]  <= in_num_q;
    tag_q[0]  <= in_tag_q;
    negq_q[0] <= s0_num_neg ^ s0_den_neg;
    negr_q[0] <= s0_num_neg;
    dz_q[0]   <= s0_div0;
    ov_q[0]   <= s0_ovf;
    for (int i = 1; i <= int'(N); i++) begin
      rem_q[i]  <= rem_d[i];
      aq_q[i]   <= aq_d[i];
      num_q[i]  <= num_q[i-1];
      tag_q[i]  <= tag_q[i-1];
      negq_q[i] <= negq_q[i-1];
      negr_q[i] <= negr_q[i-1];
      dz_q[i]   <= dz_q[i-1];
      ov_q[i]   <= ov_q[i-1];
    end
    for (int i = 1; i < int'(N); i++) begin
      b_q[i] <= b_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------------------
  logic [W-1:0]    coc_d;
  logic [W-1:0]    res_d;
  logic [W-1:0]    coc_q;
  logic [W-1:0]    res_q;
  logic            div0_q;
  logic [TAGW-1:0] tag_out_q;
  logic            done_q;
  logic            complete;

  always_comb begin
    coc_d = aq_q[N];
    res_d = rem_q[N];
    if (dz_q[N]) begin
      coc_d = '1;
      res_d = num_q[N];
    end else if (ov_q[N]) begin
      coc_d = num_q[N];
      res_d = '0;
    end else begin
      if (negq_q[N]) coc_d = -aq_q[N];
      if (negr_q[N]) res_d = -rem_q[N];
    end
  end

  // An operation reaching the output on a flush edge was accepted earlier, so it is killed too.
  assign complete = vld_q[N] & ~FLUSH;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      in_vld_q  <= 1'b0;
      vld_q     <= '0;
      coc_q     <= '0;
      res_q     <= '0;
      div0_q    <= 1'b0;
      tag_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      // A START coinciding with FLUSH is newer than the flush and survives it.
      in_vld_q <= START;
      vld_q    <= FLUSH ? '0 : {vld_q[N-1:0], in_vld_q};
      done_q   <= complete;
      if (complete) begin
        coc_q     <= coc_d;
        res_q     <= res_d;
        div0_q    <= dz_q[N];
        tag_out_q <= tag_q[N];
      end
    end
  end

  assign COC     = coc_q;
  assign RES     = res_q;
  assign DIV0    = div0_q;
  assign TAG_OUT = tag_out_q;
  assign DONE    = done_q;

endmodule
